// File: rtl/trace_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_pkg                                                            |
// | Commit-trace record layout, event kinds, fail codes, FSM states.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package trace_pkg;

  localparam int ENTRY_W = 54;

  typedef enum logic [1:0] {
    K_NOP   = 2'd0,
    K_REG   = 2'd1,
    K_STORE = 2'd2,
    K_HALT  = 2'd3
  } kind_e;

  typedef enum logic [2:0] {
    FC_NONE     = 3'd0,
    FC_KIND     = 3'd1,
    FC_PC       = 3'd2,
    FC_DEST     = 3'd3,
    FC_VALUE    = 3'd4,
    FC_OVERRUN  = 3'd5,
    FC_TIMEOUT  = 3'd6,
    FC_TRAILING = 3'd7
  } fail_code_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_e;

  // Field order gives kind[53:52] pc[51:36] reg[35:32] value[31:16] addr[15:0].
  typedef struct packed {
    kind_e       kind;
    logic [15:0] pc;
    logic [3:0]  rd;
    logic [15:0] value;
    logic [15:0] addr;
  } rec_t;

  function automatic rec_t pack_event(
    input logic        regwrite,
    input logic        halt,
    input logic        memwrite,
    input logic [15:0] pc,
    input logic [3:0]  wreg,
    input logic [15:0] wdata,
    input logic [15:0] maddr,
    input logic [15:0] mdata
  );
    rec_t r;
    r    = '0;
    r.pc = pc;
    if (regwrite) begin
      r.kind  = K_REG;
      r.rd    = wreg;
      r.value = wdata;
    end else if (halt) begin
      r.kind = K_HALT;
    end else if (memwrite) begin
      r.kind  = K_STORE;
      r.value = mdata;
      r.addr  = maddr;
    end else begin
      r.kind = K_NOP;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/commit_trace_checker_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | commit_trace_checker_if                                              |
// | Per-instruction retire event bus from the cpu to the trace checker.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface commit_trace_checker_if;
  logic        cm_valid;
  logic [15:0] cm_pc;
  logic        cm_regwrite;
  logic [3:0]  cm_wreg;
  logic [15:0] cm_wdata;
  logic        cm_memwrite;
  logic [15:0] cm_maddr;
  logic [15:0] cm_mdata;
  logic        cm_halt;

  modport master (
    output cm_valid, cm_pc, cm_regwrite, cm_wreg, cm_wdata,
           cm_memwrite, cm_maddr, cm_mdata, cm_halt
  );

  modport slave (
    input cm_valid, cm_pc, cm_regwrite, cm_wreg, cm_wdata,
          cm_memwrite, cm_maddr, cm_mdata, cm_halt
  );
endinterface
`default_nettype wire

// File: rtl/trace_golden_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trace_golden_mem                                                     |
// | Golden trace table: synchronous write, asynchronous read, no reset.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module trace_golden_mem
  import trace_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  wire logic               clk,
  input  wire logic               i_we,
  input  wire logic [AW-1:0]      i_waddr,
  input  wire logic [ENTRY_W-1:0] i_wdata,
  input  wire logic [AW-1:0]      i_raddr,
  output logic      [ENTRY_W-1:0] o_rdata
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/commit_trace_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | commit_trace_checker                                                 |
// | Compares retired-instruction events against a preloaded golden trace |
// | and latches a sticky pass/fail verdict with diagnostics.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module commit_trace_checker
  import trace_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int AW      = 10,
  parameter int TIMEOUT = 4096
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  commit_trace_checker_if.slave   cm,
  input  wire logic               i_gold_we,
  input  wire logic [AW-1:0]      i_gold_addr,
  input  wire logic [ENTRY_W-1:0] i_gold_wdata,
  input  wire logic [AW:0]        i_num_entries,
  input  wire logic               i_start,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_pass,
  output logic                    o_fail,
  output logic [2:0]              o_fail_code,
  output logic [AW:0]             o_fail_inum,
  output logic [ENTRY_W-1:0]      o_exp_word,
  output logic [ENTRY_W-1:0]      o_act_word
);

  localparam int              c_IDLE_W   = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]     c_INUM_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [c_IDLE_W-1:0] c_IDLE_ONE = {{(c_IDLE_W-1){1'b0}}, 1'b1};
  localparam logic [c_IDLE_W-1:0] c_IDLE_MAX = c_IDLE_W'(TIMEOUT - 1);

  state_e               r_state, w_state_nxt;
  logic [AW:0]          r_inum, r_num, r_fail_inum, w_inum_inc;
  logic [c_IDLE_W-1:0]  r_idle_cnt;
  fail_code_e           r_fail_code, w_code, w_fail_code_nxt;
  logic [ENTRY_W-1:0]   r_exp_word, r_act_word, w_gold_word;
  rec_t                 w_gold, w_act;
  logic                 w_overrun, w_fail_now, w_timeout;

  trace_golden_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (i_gold_we && (r_state != S_RUN)),
    .i_waddr (i_gold_addr),
    .i_wdata (i_gold_wdata),
    .i_raddr (r_inum[AW-1:0]),
    .o_rdata (w_gold_word)
  );

  assign w_gold     = rec_t'(w_gold_word);
  assign w_act      = pack_event(cm.cm_regwrite, cm.cm_halt, cm.cm_memwrite, cm.cm_pc,
                                 cm.cm_wreg, cm.cm_wdata, cm.cm_maddr, cm.cm_mdata);
  assign w_overrun  = (r_inum >= r_num);
  assign w_inum_inc = r_inum + c_INUM_ONE;
  assign w_timeout  = !cm.cm_valid && (r_idle_cnt == c_IDLE_MAX);

  // Mismatch classification; earlier checks shadow later ones.
  always_comb begin
    w_code = FC_NONE;
    if (w_overrun) begin
      w_code = FC_OVERRUN;
    end else if (w_act.kind != w_gold.kind) begin
      w_code = FC_KIND;
    end else if (w_act.pc != w_gold.pc) begin
      w_code = FC_PC;
    end else if (((w_gold.kind == K_REG)   && (w_act.rd   != w_gold.rd)) ||
                 ((w_gold.kind == K_STORE) && (w_act.addr != w_gold.addr))) begin
      w_code = FC_DEST;
    end else if (w_act.value != w_gold.value) begin
      w_code = FC_VALUE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_fail_now      = 1'b0;
    w_fail_code_nxt = FC_NONE;
    case (r_state)
      S_RUN: begin
        if (cm.cm_valid) begin
          if (w_code != FC_NONE) begin
            w_fail_now      = 1'b1;
            w_fail_code_nxt = w_code;
          end else if (w_act.kind == K_HALT) begin
            if (w_inum_inc == r_num) begin
              w_state_nxt = S_PASS;
            end else begin
              w_fail_now      = 1'b1;
              w_fail_code_nxt = FC_TRAILING;
            end
          end
        end else if (w_timeout) begin
          w_fail_now      = 1'b1;
          w_fail_code_nxt = FC_TIMEOUT;
        end
        if (w_fail_now) begin
          w_state_nxt = S_FAIL;
        end
      end
      default: begin
        if (i_start) begin
          w_state_nxt = S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inum      <= '0;
      r_num       <= '0;
      r_idle_cnt  <= '0;
      r_fail_code <= FC_NONE;
      r_fail_inum <= '0;
      r_exp_word  <= '0;
      r_act_word  <= '0;
    end else if (r_state != S_RUN) begin
      if (i_start) begin
        r_num       <= i_num_entries;
        r_inum      <= '0;
        r_idle_cnt  <= '0;
        r_fail_code <= FC_NONE;
        r_fail_inum <= '0;
        r_exp_word  <= '0;
        r_act_word  <= '0;
      end
    end else begin
      if (cm.cm_valid) begin
        r_idle_cnt <= '0;
        if (w_code == FC_NONE) begin
          r_inum <= w_inum_inc;
        end
      end else begin
        r_idle_cnt <= r_idle_cnt + c_IDLE_ONE;
      end
      if (w_fail_now) begin
        r_fail_code <= w_fail_code_nxt;
        r_fail_inum <= r_inum;
        r_exp_word  <= w_overrun ? '0 : w_gold_word;
        r_act_word  <= cm.cm_valid ? w_act : '0;
      end
    end
  end

  assign o_busy      = (r_state == S_RUN);
  assign o_pass      = (r_state == S_PASS);
  assign o_fail      = (r_state == S_FAIL);
  assign o_done      = o_pass || o_fail;
  assign o_fail_code = r_fail_code;
  assign o_fail_inum = r_fail_inum;
  assign o_exp_word  = r_exp_word;
  assign o_act_word  = r_act_word;

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_commit_trace_checker                                              |
// | Directed and randomized commit streams against a trace-level model.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_commit_trace_checker;

  localparam int DEPTH   = 1024;
  localparam int AW      = 10;
  localparam int TIMEOUT = 4096;

  typedef struct packed {
    logic [15:0] pc;
    logic        rw;
    logic [3:0]  wreg;
    logic [15:0] wdata;
    logic        mw;
    logic [15:0] maddr;
    logic [15:0] mdata;
    logic        halt;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gold_we = 1'b0;
  logic [AW-1:0] gold_addr = '0;
  logic [53:0] gold_wdata = '0;
  logic [AW:0] num_entries = '0;
  logic        start = 1'b0;
  logic        busy, done, pass, fail;
  logic [2:0]  fail_code;
  logic [AW:0] fail_inum;
  logic [53:0] exp_word, act_word;

  int          n_vec = 0;
  int          n_err = 0;
  logic [53:0] m_tab [DEPTH];
  int          m_num = 0;
  bit          m_running = 1'b0;
  ev_t         evq[$];

  commit_trace_checker_if cm_if();

  commit_trace_checker #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cm            (cm_if),
    .i_gold_we     (gold_we),
    .i_gold_addr   (gold_addr),
    .i_gold_wdata  (gold_wdata),
    .i_num_entries (num_entries),
    .i_start       (start),
    .o_busy        (busy),
    .o_done        (done),
    .o_pass        (pass),
    .o_fail        (fail),
    .o_fail_code   (fail_code),
    .o_fail_inum   (fail_inum),
    .o_exp_word    (exp_word),
    .o_act_word    (act_word)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [53:0] rec(input logic [1:0] k, input logic [15:0] pc,
                                      input logic [3:0] r, input logic [15:0] v,
                                      input logic [15:0] a);
    return {k, pc, r, v, a};
  endfunction

  function automatic ev_t mk(input logic [1:0] k, input logic [15:0] pc,
                             input logic [3:0] r, input logic [15:0] v, input logic [15:0] a);
    ev_t e;
    e = '0;
    e.pc = pc;
    case (k)
      2'd1: begin e.rw = 1'b1; e.wreg = r; e.wdata = v; end
      2'd2: begin e.mw = 1'b1; e.maddr = a; e.mdata = v; end
      2'd3: e.halt = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  // What the cpu event means as a trace record.
  function automatic logic [53:0] act_of(input ev_t e);
    if (e.rw)   return rec(2'd1, e.pc, e.wreg, e.wdata, 16'h0);
    if (e.halt) return rec(2'd3, e.pc, 4'h0, 16'h0, 16'h0);
    if (e.mw)   return rec(2'd2, e.pc, 4'h0, e.mdata, e.maddr);
    return rec(2'd0, e.pc, 4'h0, 16'h0, 16'h0);
  endfunction

  // -1: matched, keep going; 0: pass; 1..7: fail code.
  function automatic int ref_step(input int i, input ev_t e);
    logic [53:0] g, a;
    a = act_of(e);
    if (i >= m_num) return 5;
    g = m_tab[i];
    if (g[53:52] != a[53:52]) return 1;
    if (g[51:36] != a[51:36]) return 2;
    if ((g[53:52] == 2'd1 && g[35:32] != a[35:32]) ||
        (g[53:52] == 2'd2 && g[15:0] != a[15:0])) return 3;
    if (g[31:16] != a[31:16]) return 4;
    if (g[53:52] == 2'd3) return (i + 1 == m_num) ? 0 : 7;
    return -1;
  endfunction

  task automatic drive_ev(input ev_t e, input logic v);
    cm_if.cm_valid    = v;
    cm_if.cm_pc       = e.pc;
    cm_if.cm_regwrite = e.rw;
    cm_if.cm_wreg     = e.wreg;
    cm_if.cm_wdata    = e.wdata;
    cm_if.cm_memwrite = e.mw;
    cm_if.cm_maddr    = e.maddr;
    cm_if.cm_mdata    = e.mdata;
    cm_if.cm_halt     = e.halt;
  endtask

  task automatic load(input int idx, input logic [53:0] w);
    @(negedge clk);
    gold_we    = 1'b1;
    gold_addr  = AW'(idx);
    gold_wdata = w;
    @(negedge clk);
    gold_we = 1'b0;
    if (!m_running) m_tab[idx] = w;
  endtask

  task automatic do_start(input int n);
    @(negedge clk);
    start       = 1'b1;
    num_entries = (AW+1)'(n);
    @(negedge clk);
    start     = 1'b0;
    m_num     = n;
    m_running = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_running = 1'b0;
  endtask

  task automatic run_and_check(input string tag);
    int d, r, last;
    d = -1;
    r = -1;
    for (int i = 0; i < evq.size(); i++) begin
      r = ref_step(i, evq[i]);
      if (r >= 0) begin d = i; break; end
    end
    last = (d < 0) ? evq.size() - 1 : d;
    for (int i = 0; i <= last; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      check_val({tag, "_busy"}, 64'(busy), 64'd1);
      drive_ev(evq[i], 1'b1);
      @(negedge clk);
      cm_if.cm_valid = 1'b0;
    end
    if (d < 0) begin
      check_val({tag, "_undecided_busy"}, 64'(busy), 64'd1);
      do_reset();
      return;
    end
    m_running = 1'b0;
    check_val({tag, "_done"}, 64'(done), 64'd1);
    check_val({tag, "_pass"}, 64'(pass), 64'(r == 0));
    check_val({tag, "_fail"}, 64'(fail), 64'(r != 0));
    check_val({tag, "_code"}, 64'(fail_code), 64'(r));
    check_val({tag, "_inum"}, 64'(fail_inum), (r == 0) ? 64'd0 : 64'(d));
    check_val({tag, "_exp"}, 64'(exp_word),
              (r == 0 || r == 5) ? 64'd0 : 64'(m_tab[d]));
    check_val({tag, "_act"}, 64'(act_word), (r == 0) ? 64'd0 : 64'(act_of(evq[d])));
  endtask

  task automatic load_basic();
    load(0, rec(2'd1, 16'h0000, 4'd1, 16'h0005, 16'h0000));
    load(1, rec(2'd2, 16'h0002, 4'd0, 16'h0005, 16'h0010));
    load(2, rec(2'd3, 16'h0004, 4'd0, 16'h0000, 16'h0000));
  endtask

  task automatic basic_q();
    evq.delete();
    evq.push_back(mk(2'd1, 16'h0000, 4'd1, 16'h0005, 16'h0000));
    evq.push_back(mk(2'd2, 16'h0002, 4'd0, 16'h0005, 16'h0010));
    evq.push_back(mk(2'd3, 16'h0004, 4'd0, 16'h0000, 16'h0000));
  endtask

  initial begin
    ev_t e;
    int  len, mode, k;
    logic [1:0] kd;
    logic [53:0] w;

    drive_ev('0, 1'b0);
    repeat (3) @(negedge clk);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_pass", 64'(pass), 64'd0);
    check_val("rst_fail", 64'(fail), 64'd0);
    check_val("rst_code", 64'(fail_code), 64'd0);
    check_val("rst_inum", 64'(fail_inum), 64'd0);
    check_val("rst_exp", 64'(exp_word), 64'd0);
    check_val("rst_act", 64'(act_word), 64'd0);
    rst_n = 1'b1;

    load_basic();
    basic_q();
    do_start(3);
    run_and_check("t_match");
    check_val("t_match_pass_k", 64'(pass), 64'd1);
    check_val("t_match_fail_k", 64'(fail), 64'd0);

    basic_q();
    evq[1].mdata = 16'h0006;
    do_start(3);
    run_and_check("t_value");
    check_val("t_value_code_k", 64'(fail_code), 64'd4);
    check_val("t_value_inum_k", 64'(fail_inum), 64'd1);
    check_val("t_value_act_k", 64'(act_word[31:16]), 64'h6);

    basic_q();
    evq[0].wreg = 4'd2;
    do_start(3);
    run_and_check("t_dest");
    check_val("t_dest_code_k", 64'(fail_code), 64'd3);

    evq[0].pc = 16'h0001;
    do_start(3);
    run_and_check("t_pc");
    check_val("t_pc_code_k", 64'(fail_code), 64'd2);

    basic_q();
    evq[2] = mk(2'd0, 16'h0004, 4'd0, 16'h0, 16'h0);
    do_start(2);
    run_and_check("t_overrun");
    check_val("t_overrun_code_k", 64'(fail_code), 64'd5);

    load(1, rec(2'd3, 16'h0002, 4'd0, 16'h0000, 16'h0000));
    evq.delete();
    evq.push_back(mk(2'd1, 16'h0000, 4'd1, 16'h0005, 16'h0000));
    evq.push_back(mk(2'd3, 16'h0002, 4'd0, 16'h0000, 16'h0000));
    do_start(3);
    run_and_check("t_trail");
    check_val("t_trail_code_k", 64'(fail_code), 64'd7);
    check_val("t_trail_inum_k", 64'(fail_inum), 64'd1);

    evq.delete();
    evq.push_back(mk(2'd1, 16'h0000, 4'd1, 16'h0005, 16'h0000));
    do_start(0);
    run_and_check("t_empty");
    check_val("t_empty_code_k", 64'(fail_code), 64'd5);

    load_basic();
    do_start(3);
    repeat (TIMEOUT - 1) @(negedge clk);
    check_val("t_tmo_early_fail", 64'(fail), 64'd0);
    check_val("t_tmo_early_busy", 64'(busy), 64'd1);
    @(negedge clk);
    m_running = 1'b0;
    check_val("t_tmo_fail", 64'(fail), 64'd1);
    check_val("t_tmo_code", 64'(fail_code), 64'd6);
    check_val("t_tmo_inum", 64'(fail_inum), 64'd0);

    basic_q();
    do_start(3);
    @(negedge clk);
    drive_ev(evq[0], 1'b1);
    @(negedge clk);
    cm_if.cm_valid = 1'b0;
    load(0, rec(2'd3, 16'hBEEF, 4'd0, 16'h0, 16'h0));
    do_reset();
    check_val("t_rst_busy", 64'(busy), 64'd0);
    check_val("t_rst_done", 64'(done), 64'd0);
    do_start(3);
    run_and_check("t_rerun");
    check_val("t_rerun_pass_k", 64'(pass), 64'd1);

    for (int it = 0; it < 40; it++) begin
      len = $urandom_range(1, 12);
      evq.delete();
      for (int i = 0; i < len; i++) begin
        kd = (i == len - 1) ? 2'd3 : 2'($urandom_range(0, 2));
        w  = rec(kd, 16'($urandom), 4'($urandom), 16'($urandom), 16'($urandom));
        if (kd != 2'd1) w[35:32] = 4'h0;
        if (kd != 2'd2) w[15:0]  = 16'h0;
        if (kd == 2'd0 || kd == 2'd3) w[31:16] = 16'h0;
        load(i, w);
        e = mk(kd, w[51:36], w[35:32], w[31:16], w[15:0]);
        if (kd == 2'd1) begin
          e.mw = 1'($urandom); e.halt = 1'($urandom);
          e.maddr = 16'($urandom); e.mdata = 16'($urandom);
        end else begin
          e.wreg = 4'($urandom); e.wdata = 16'($urandom);
          if (kd == 2'd3) e.mw = 1'($urandom);
          if (kd != 2'd2) begin e.maddr = 16'($urandom); e.mdata = 16'($urandom); end
        end
        evq.push_back(e);
      end
      mode = $urandom_range(0, 3);
      if (mode == 1) begin
        k = $urandom_range(0, len - 1);
        case ($urandom_range(0, 4))
          0: evq[k].pc    = evq[k].pc    ^ 16'(1 << $urandom_range(0, 15));
          1: evq[k].wdata = evq[k].wdata ^ 16'(1 << $urandom_range(0, 15));
          2: evq[k].mdata = evq[k].mdata ^ 16'(1 << $urandom_range(0, 15));
          3: evq[k].maddr = evq[k].maddr ^ 16'(1 << $urandom_range(0, 15));
          default: evq[k].rw = ~evq[k].rw;
        endcase
      end
      do_start((mode == 2) ? len - 1 : (mode == 3) ? len + 1 : len);
      run_and_check("rnd");
      // Commits after the verdict must leave it untouched.
      @(negedge clk);
      drive_ev(evq[0], 1'b1);
      @(negedge clk);
      cm_if.cm_valid = 1'b0;
      check_val("rnd_sticky_done", 64'(done), 64'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
